// File: rtl/fpu_dispatch.sv
// Generic FIFO: zero-latency show-ahead read, one push and one pop per cycle.
// push_rdy drops when full (registered count); pop_vld is low when empty.
module fpu_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_vld,
   output logic             push_rdy,
   input  logic [WIDTH-1:0] push_dat,
   output logic             pop_vld,
   input  logic             pop_rdy,
   output logic [WIDTH-1:0] pop_dat
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      cnt;
   logic             push;
   logic             pop;

   assign push_rdy = (cnt != FULL);
   assign pop_vld  = (cnt != '0);
   assign push     = push_vld && push_rdy;
   assign pop      = pop_vld && pop_rdy;
   assign pop_dat  = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// Front-end for the non-pipelined add/sub FPU: queues tagged requests, issues one at a time.
// Start pulse 2 cycles after accept when idle; req_ready drops when the FIFO is full, a held result stalls the FSM.
module fpu_dispatch #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_op,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             fpu_start,
   output logic             fpu_op,
   output logic [31:0]      fpu_a,
   output logic [31:0]      fpu_b,
   input  logic             fpu_ready,
   input  logic [31:0]      fpu_c,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [31:0]      res_c,
   output logic [TAG_W-1:0] res_tag,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);
   typedef struct packed {
      logic             op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, HOLD} state_t;

   state_t                  state;
   state_t                  state_nxt;
   req_t                    push_dat;
   req_t                    head;
   logic [$bits(req_t)-1:0] head_raw;
   logic                    fifo_vld;
   logic                    pop;
   logic                    capture;
   logic                    slot_free;
   logic                    res_hs;
   logic [TAG_W-1:0]        tag_q;

   assign push_dat = {req_op, req_a, req_b, req_tag};
   assign head     = req_t'(head_raw);

   fpu_fifo #(
      .WIDTH ($bits(req_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (req_valid),
      .push_rdy (req_ready),
      .push_dat (push_dat),
      .pop_vld  (fifo_vld),
      .pop_rdy  (pop),
      .pop_dat  (head_raw)
   );

   assign res_hs    = res_valid && res_ready;
   assign slot_free = !res_valid || res_ready;
   assign fpu_start = (state == ISSUE);
   assign busy      = fifo_vld || (state != IDLE) || res_valid;

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_vld && fpu_ready) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT_LOW;
         WAIT_LOW: begin
            if (!fpu_ready) begin
               state_nxt = WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (fpu_ready) begin
               if (slot_free) begin
                  capture   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = HOLD;
               end
            end
         end
         // No new start is issued here, so fpu_c stays valid until the slot frees.
         HOLD: begin
            if (slot_free) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         fpu_op    <= 1'b0;
         fpu_a     <= '0;
         fpu_b     <= '0;
         tag_q     <= '0;
         res_valid <= 1'b0;
         res_c     <= '0;
         res_tag   <= '0;
         done_cnt  <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            fpu_op <= head.op;
            fpu_a  <= head.a;
            fpu_b  <= head.b;
            tag_q  <= head.tag;
         end
         if (capture) begin
            res_valid <= 1'b1;
            res_c     <= fpu_c;
            res_tag   <= tag_q;
         end else if (res_hs) begin
            res_valid <= 1'b0;
         end
         if (res_hs) begin
            done_cnt <= done_cnt + 1'b1;
         end
      end
   end
endmodule
